// File: rtl/pong_pkg.sv
// Shared geometry, colour constants and types for the pong block renderer.
package pong_pkg;

  localparam int unsigned GridW      = 32;
  localparam int unsigned GridH      = 24;
  localparam int unsigned PaddleH    = 4;
  localparam int unsigned PaddleLCol = 1;
  localparam int unsigned PaddleRCol = 30;
  localparam int unsigned NetCol     = 16;

  typedef logic [4:0]  cell_t;
  typedef logic [11:0] rgb12_t;

  localparam rgb12_t ColorBg     = 12'h000;
  localparam rgb12_t ColorPaddle = 12'hFFF;
  localparam rgb12_t ColorBall   = 12'hF00;
  localparam rgb12_t ColorNet    = 12'h888;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StDone
  } state_e;

endpackage

// File: rtl/pong_cell_shader.sv
// Combinational priority colour for one grid cell: ball, then paddles, then net, else background.
module pong_cell_shader
  import pong_pkg::*;
#(
  parameter int unsigned PaddleHeight = PaddleH,
  parameter int unsigned LeftCol      = PaddleLCol,
  parameter int unsigned RightCol     = PaddleRCol,
  parameter int unsigned NetColumn    = NetCol
) (
  input  logic [4:0]  x_i,
  input  logic [4:0]  y_i,
  input  logic [4:0]  ball_x_i,
  input  logic [4:0]  ball_y_i,
  input  logic [4:0]  paddle_l_y_i,
  input  logic [4:0]  paddle_r_y_i,
  output logic [11:0] color_o
);

  // Bounds held at 6 bits so top + height cannot wrap; rows past the grid are never visited.
  function automatic logic in_paddle(input logic [4:0] row, input logic [4:0] top);
    logic [5:0] lo;
    logic [5:0] hi;
    lo = {1'b0, top};
    hi = lo + 6'(PaddleHeight);
    return ({1'b0, row} >= lo) && ({1'b0, row} < hi);
  endfunction

  logic hit_ball;
  logic hit_paddle;
  logic hit_net;

  always_comb begin
    hit_ball   = (x_i == ball_x_i) && (y_i == ball_y_i);
    hit_paddle = ((x_i == cell_t'(LeftCol)) && in_paddle(y_i, paddle_l_y_i)) ||
                 ((x_i == cell_t'(RightCol)) && in_paddle(y_i, paddle_r_y_i));
    hit_net    = (x_i == cell_t'(NetColumn)) && !y_i[0];

    color_o = ColorBg;
    if (hit_ball) begin
      color_o = ColorBall;
    end else if (hit_paddle) begin
      color_o = ColorPaddle;
    end else if (hit_net) begin
      color_o = ColorNet;
    end
  end

endmodule

// File: rtl/pong_frame_writer.sv
// Snapshots game positions on frame_start and streams one colour write per cell, row-major.
module pong_frame_writer
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start_i,
  input  logic [4:0]  ball_x_i,
  input  logic [4:0]  ball_y_i,
  input  logic [4:0]  paddle_l_y_i,
  input  logic [4:0]  paddle_r_y_i,
  output logic        wr_valid_o,
  input  logic        wr_ready_i,
  output logic [4:0]  wr_x_o,
  output logic [4:0]  wr_y_o,
  output logic [11:0] wr_color_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o
);

  state_e state_q, state_d;
  cell_t  x_q, x_d, y_q, y_d;
  cell_t  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  cell_t  pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  logic   overrun_q, overrun_d;
  rgb12_t shade;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      ball_x_q  <= '0;
      ball_y_q  <= '0;
      pad_l_q   <= '0;
      pad_r_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      pad_l_q   <= pad_l_d;
      pad_r_q   <= pad_r_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    pad_l_d   = pad_l_q;
    pad_r_d   = pad_r_q;
    overrun_d = frame_start_i && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (frame_start_i) begin
          ball_x_d = ball_x_i;
          ball_y_d = ball_y_i;
          pad_l_d  = paddle_l_y_i;
          pad_r_d  = paddle_r_y_i;
          x_d      = '0;
          y_d      = '0;
          state_d  = StDraw;
        end
      end
      StDraw: begin
        if (wr_ready_i) begin
          if (x_q == cell_t'(GridW - 1)) begin
            x_d = '0;
            if (y_q == cell_t'(GridH - 1)) begin
              y_d     = '0;
              state_d = StDone;
            end else begin
              y_d = y_q + 5'd1;
            end
          end else begin
            x_d = x_q + 5'd1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  pong_cell_shader u_shader (
    .x_i          (x_q),
    .y_i          (y_q),
    .ball_x_i     (ball_x_q),
    .ball_y_i     (ball_y_q),
    .paddle_l_y_i (pad_l_q),
    .paddle_r_y_i (pad_r_q),
    .color_o      (shade)
  );

  assign wr_valid_o = (state_q == StDraw);
  assign busy_o     = (state_q == StDraw);
  assign done_o     = (state_q == StDone);
  assign overrun_o  = overrun_q;
  assign wr_x_o     = x_q;
  assign wr_y_o     = y_q;
  // Blank the colour outside a sweep so idle outputs read as zero.
  assign wr_color_o = (state_q == StDraw) ? shade : '0;

endmodule

// File: doc/pong_frame_writer.md
Name: pong_frame_writer

Overview:
- Producer side of the pong block framebuffer. The framebuffer is a 32x24 grid of 20x20-pixel cells with 12-bit RGB per cell.
- On each frame_start pulse the block snapshots the game-object positions. It then sweeps every cell in row-major order and emits one colour write per cell over a valid/ready write port.
- The framebuffer's back-buffer write side consumes these writes. The block sits between game logic (ball and paddle position registers) and the framebuffer.

Parameters:
- GRID_W, 32: cells per row.
- GRID_H, 24: cells per column.
- PADDLE_H, 4: paddle height in cells.
- PADDLE_L_COL, 1: left paddle column.
- PADDLE_R_COL, 30: right paddle column.
- NET_COL, 16: centre-net column.
- COLOR_BG, 12'h000: background colour.
- COLOR_PADDLE, 12'hFFF: paddle colour.
- COLOR_BALL, 12'hF00: ball colour.
- COLOR_NET, 12'h888: net colour.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- frame_start, input, 1: single-cycle request to render one frame.
- ball_x, input, 5: ball cell column.
- ball_y, input, 5: ball cell row.
- paddle_l_y, input, 5: top row of the left paddle.
- paddle_r_y, input, 5: top row of the right paddle.
- wr_valid, output, 1: write beat valid.
- wr_ready, input, 1: framebuffer accepts the beat.
- wr_x, output, 5: cell column of the current beat.
- wr_y, output, 5: cell row of the current beat.
- wr_color, output, 12: cell colour.
- busy, output, 1: a frame is in progress.
- done, output, 1: one-cycle pulse after the last beat of a frame is accepted.
- overrun, output, 1: one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Reset: synchronous, active-high; clock clk. State goes to IDLE. wr_valid, busy, done and overrun are 0; wr_x, wr_y and wr_color are 0. Reset mid-frame abandons the sweep immediately, with no further beats.
- FSM states are IDLE, DRAW and DONE.
- IDLE:
  - On a clock edge with frame_start=1, the block snapshots ball_x, ball_y, paddle_l_y and paddle_r_y into internal registers and moves to DRAW.
  - From the next cycle, wr_valid=1 with wr_x=0, wr_y=0, and busy=1.
- DRAW:
  - The beat is transferred on any edge where wr_valid and wr_ready are both 1.
  - While wr_ready=0, wr_x, wr_y and wr_color are held stable.
  - On transfer, wr_x increments. When wr_x reaches GRID_W-1, it wraps to 0 and wr_y increments.
  - Transfer of cell (GRID_W-1, GRID_H-1) moves to DONE, with wr_valid=0 in the next cycle.
- DONE: lasts one cycle with done=1 and busy=0, then returns to IDLE.
- Beat count is exactly GRID_W*GRID_H = 768 per frame. With wr_ready held at 1, done asserts exactly 769 cycles after the frame_start edge.
- Colour for cell (x,y) is computed from the snapshot only, never from live inputs. The first matching rule wins:
  1. Ball: x==ball_x and y==ball_y.
  2. Paddle: x==PADDLE_L_COL and paddle_l_y <= y < paddle_l_y+PADDLE_H, or the same test with PADDLE_R_COL and paddle_r_y.
  3. Net: x==NET_COL and y[0]==0.
  4. Otherwise COLOR_BG.
- Arithmetic: paddle bounds are computed at 6 bits so that paddle_y+PADDLE_H never wraps. Paddle rows at or beyond GRID_H are simply never visited, which gives clipping. A ball_x >= GRID_W or ball_y >= GRID_H draws no ball.
- Colour may be computed combinationally from the cell counters, or registered one stage ahead. Either way wr_color must correspond to the current wr_x and wr_y in the same cycle.
- frame_start while in DRAW or DONE is ignored: no restart and no snapshot update, and overrun pulses for one cycle.
- frame_start on the same edge that reset is asserted: reset wins.

Decomposition:
- Package pong_pkg holds GRID_W, GRID_H, the colour constants, the cell-coordinate typedef (5-bit) and the rgb12 typedef.
- One natural sub-module, pong_cell_shader. It is a combinational priority colour function of (x, y, snapshot) that returns rgb12. It is reusable by other renderers.

Test Plan:
- Reset, then idle 10 cycles -> wr_valid, busy, done and overrun stay 0; wr_x and wr_y stay 0.
- frame_start with ball=(5,7), paddle_l_y=3, paddle_r_y=20, wr_ready=1:
  - 768 beats in row-major order; done exactly 769 cycles after frame_start.
  - (5,7)=F00; (1,3..6)=FFF; (30,20..23)=FFF; (16,0)=888; (16,1)=000; (0,0)=000.
- Backpressure: wr_ready toggling on a pseudo-random pattern -> every cell written exactly once, outputs stable while stalled, done only after the 768th acceptance.
- Snapshot isolation: change ball_x mid-frame, and separately pulse frame_start at beat 100 -> ball still drawn at the snapshot position, overrun pulses once, no restart, 768 beats total.
- Clip and overlap: paddle_l_y=22 -> only rows 22 and 23 of column 1 are FFF. Ball at (1,22) -> F00 over the paddle. ball_x=31 -> ball drawn in column 31; ball_x=31 with ball_y=24 -> no F00 anywhere.
- Reset asserted at beat 300, then a new frame_start -> wr_valid drops the cycle after reset. The new frame restarts at (0,0) with 768 beats and no leftover done.
